// File: rtl/imem_responder.sv
// Instruction-memory responder: byte-serial program loader, combinational fetch port and core reset sequencing.
// Optional build macro IMEM_BOUNDS_CHECK_EN adds fetch bounds checking and a fetch_fault_o pulse.
module imem_responder #(
    parameter int          DEPTH    = 1024,
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       fetch_addr_i,
    input  logic              fetch_ce_i,
    output logic [31:0]       fetch_data_o,
    output logic              core_rst_o,
    input  logic              ld_start_i,
    input  logic [7:0]        ld_byte_i,
    input  logic              ld_valid_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    output logic [ADDR_W:0]   words_loaded_o,
    output logic              load_done_o,
    output logic              overflow_o
`ifdef IMEM_BOUNDS_CHECK_EN
    ,
    output logic              fetch_fault_o
`endif
);

    if ((1 << ADDR_W) != DEPTH) begin : g_bad_geometry
        $error("imem_responder: DEPTH must equal 2**ADDR_W");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W + 1)'(1);

    state_t            state_q;
    logic              ready_q;
    logic              done_q;
    logic              core_rst_q;
    logic              ovf_q;
    logic [ADDR_W:0]   wcnt_q;
    logic [1:0]        lane_q;
    logic [31:0]       asm_q;

    logic [31:0]       mem_q [DEPTH];

    logic              accept_d;
    logic              close_d;
    logic              full_d;
    logic              wr_en_d;
    logic [31:0]       word_d;
    logic [ADDR_W-1:0] fetch_idx_d;
    logic              rd_ok_d;
    logic              oob_d;

    // A start pulse wins over a byte presented on the same edge: the load restarts cleanly.
    assign accept_d = ld_valid_i & ready_q & ~ld_start_i;
    assign close_d  = accept_d & ((lane_q == 2'd3) | ld_last_i);
    assign full_d   = (wcnt_q == FULL_CNT);
    assign wr_en_d  = close_d & ~full_d;
    assign word_d   = asm_q | ({24'd0, ld_byte_i} << {lane_q, 3'b000});

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            core_rst_q <= 1'b1;
            ovf_q      <= 1'b0;
            wcnt_q     <= '0;
            lane_q     <= 2'd0;
            asm_q      <= '0;
        end else begin
            // Released one cycle after RUN entry; re-asserted on the very edge a new load starts.
            core_rst_q <= (state_q != S_RUN) | ld_start_i;
            if (ld_start_i) begin
                state_q <= S_LOAD;
                ready_q <= 1'b1;
                done_q  <= 1'b0;
                ovf_q   <= 1'b0;
                wcnt_q  <= '0;
                lane_q  <= 2'd0;
                asm_q   <= '0;
            end else if (accept_d) begin
                if (close_d) begin
                    lane_q <= 2'd0;
                    asm_q  <= '0;
                    if (full_d) begin
                        ovf_q <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_q + ONE_CNT;
                    end
                end else begin
                    lane_q <= lane_q + 2'd1;
                    asm_q  <= word_d;
                end
                if (ld_last_i) begin
                    state_q <= S_RUN;
                    ready_q <= 1'b0;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_d) begin
            mem_q[wcnt_q[ADDR_W-1:0]] <= word_d;
        end
    end

    assign fetch_idx_d = fetch_addr_i[ADDR_W+1:2];
    assign rd_ok_d     = fetch_ce_i & (state_q == S_RUN);

`ifdef IMEM_BOUNDS_CHECK_EN
    logic       fault_q;
    logic [1:0] unused_addr_bits;

    assign unused_addr_bits = fetch_addr_i[1:0];
    assign oob_d = ({1'b0, fetch_idx_d} >= wcnt_q) | (|fetch_addr_i[31:ADDR_W+2]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= rd_ok_d & oob_d;
        end
    end

    assign fetch_fault_o = fault_q;
`else
    logic [31-ADDR_W:0] unused_addr_bits;

    // Upper address bits alias onto the array in this build.
    assign unused_addr_bits = {fetch_addr_i[31:ADDR_W+2], fetch_addr_i[1:0]};
    assign oob_d = 1'b0;
`endif

    assign fetch_data_o   = (rd_ok_d & ~oob_d) ? mem_q[fetch_idx_d] : NOP_WORD;
    assign core_rst_o     = core_rst_q;
    assign ld_ready_o     = ready_q;
    assign words_loaded_o = wcnt_q;
    assign load_done_o    = done_q;
    assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: a full-size and a 4-word instance share the loader/fetch inputs.
// A byte-queue model predicts every output each cycle; directed literals pin the model.
module tb_imem_responder;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_RUN  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_addr;
    logic        fetch_ce;
    logic        ld_start;
    logic [7:0]  ld_byte;
    logic        ld_valid;
    logic        ld_last;

    logic [31:0] b_data, s_data;
    logic        b_core_rst, s_core_rst;
    logic        b_ready, s_ready;
    logic [10:0] b_words;
    logic [2:0]  s_words;
    logic        b_done, s_done;
    logic        b_ovf, s_ovf;
`ifdef IMEM_BOUNDS_CHECK_EN
    logic        b_fault, s_fault;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH(1024), .ADDR_W(10)) u_big (
        .clk_i(clk), .rst_i(rst),
        .fetch_addr_i(fetch_addr), .fetch_ce_i(fetch_ce), .fetch_data_o(b_data),
        .core_rst_o(b_core_rst),
        .ld_start_i(ld_start), .ld_byte_i(ld_byte), .ld_valid_i(ld_valid), .ld_last_i(ld_last),
        .ld_ready_o(b_ready), .words_loaded_o(b_words), .load_done_o(b_done), .overflow_o(b_ovf)
`ifdef IMEM_BOUNDS_CHECK_EN
        , .fetch_fault_o(b_fault)
`endif
    );

    imem_responder #(.DEPTH(4), .ADDR_W(2)) u_small (
        .clk_i(clk), .rst_i(rst),
        .fetch_addr_i(fetch_addr), .fetch_ce_i(fetch_ce), .fetch_data_o(s_data),
        .core_rst_o(s_core_rst),
        .ld_start_i(ld_start), .ld_byte_i(ld_byte), .ld_valid_i(ld_valid), .ld_last_i(ld_last),
        .ld_ready_o(s_ready), .words_loaded_o(s_words), .load_done_o(s_done), .overflow_o(s_ovf)
`ifdef IMEM_BOUNDS_CHECK_EN
        , .fetch_fault_o(s_fault)
`endif
    );

    // ---------------- model: the image is just the queue of accepted bytes ----------------
    int         m_phase = P_IDLE;
    logic [7:0] m_bytes[$];
    bit         m_ended = 0;
    int         m_run_age = 0;
    bit         m_valid = 0;
    bit         m_fault_b = 0;
    bit         m_fault_s = 0;
    bit         m_was_run;

    function automatic int words_written();
        int n = m_bytes.size();
        return m_ended ? (n + 3) / 4 : n / 4;
    endfunction

    function automatic int exp_count(int depth);
        int w = words_written();
        return (w > depth) ? depth : w;
    endfunction

    function automatic bit exp_ovf(int depth);
        return words_written() > depth;
    endfunction

    function automatic logic [31:0] exp_word(int idx);
        logic [31:0] w = 32'd0;
        for (int k = 0; k < 4; k++) begin
            if (4 * idx + k < m_bytes.size()) w[8*k +: 8] = m_bytes[4*idx + k];
        end
        return w;
    endfunction

    function automatic int word_idx(logic [31:0] a, int aw);
        return int'((a >> 2) & ((32'd1 << aw) - 32'd1));
    endfunction

    function automatic bit oob(logic [31:0] a, int aw, int depth);
        logic [31:0] upper = a >> (aw + 2);
        return (upper != 32'd0) || (word_idx(a, aw) >= exp_count(depth));
    endfunction

    always @(posedge clk) begin
        m_was_run = (m_phase == P_RUN);
        if (rst) begin
            m_phase = P_IDLE;
            m_bytes.delete();
            m_ended = 0;
            m_run_age = 0;
            m_fault_b = 0;
            m_fault_s = 0;
            m_valid = 1;
        end else begin
            m_fault_b = m_was_run && fetch_ce && oob(fetch_addr, 10, 1024);
            m_fault_s = m_was_run && fetch_ce && oob(fetch_addr, 2, 4);
            if (ld_start) begin
                m_phase = P_LOAD;
                m_bytes.delete();
                m_ended = 0;
            end else if (m_phase == P_LOAD && ld_valid) begin
                m_bytes.push_back(ld_byte);
                if (ld_last) begin
                    m_ended = 1;
                    m_phase = P_RUN;
                    m_run_age = 0;
                end
            end else if (m_phase == P_RUN) begin
                m_run_age++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_fetch(input string nm, input logic [31:0] act, input int aw, input int depth);
        int idx = word_idx(fetch_addr, aw);
        if (!(fetch_ce && m_phase == P_RUN)) begin
            chk(nm, act, NOP);
        end
`ifdef IMEM_BOUNDS_CHECK_EN
        else if (oob(fetch_addr, aw, depth)) begin
            chk(nm, act, NOP);
        end
`endif
        else if (idx < exp_count(depth)) begin
            chk(nm, act, exp_word(idx));
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            logic exp_rst;
            exp_rst = !(m_phase == P_RUN && m_run_age >= 1);
            chk("big core_rst",   32'(b_core_rst), 32'(exp_rst));
            chk("small core_rst", 32'(s_core_rst), 32'(exp_rst));
            chk("big ready",      32'(b_ready),    32'(m_phase == P_LOAD));
            chk("small ready",    32'(s_ready),    32'(m_phase == P_LOAD));
            chk("big done",       32'(b_done),     32'(m_phase == P_RUN));
            chk("small done",     32'(s_done),     32'(m_phase == P_RUN));
            chk("big words",      32'(b_words),    32'(exp_count(1024)));
            chk("small words",    32'(s_words),    32'(exp_count(4)));
            chk("big overflow",   32'(b_ovf),      32'(exp_ovf(1024)));
            chk("small overflow", 32'(s_ovf),      32'(exp_ovf(4)));
            cmp_fetch("big fetch",   b_data, 10, 1024);
            cmp_fetch("small fetch", s_data, 2, 4);
`ifdef IMEM_BOUNDS_CHECK_EN
            chk("big fault",   32'(b_fault), 32'(m_fault_b));
            chk("small fault", 32'(s_fault), 32'(m_fault_s));
`endif
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] img[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_image(input bit with_start, input bit gaps);
        if (with_start) begin
            ld_start = 1'b1;
            tick();
            ld_start = 1'b0;
        end
        foreach (img[i]) begin
            if (gaps) begin
                ld_valid = 1'b0;
                ld_byte  = 8'hEE;
                ld_last  = 1'b1;
                tick();
            end
            ld_valid = 1'b1;
            ld_byte  = img[i];
            ld_last  = (i == img.size() - 1);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic fetch_chk(input string nm, input logic [31:0] a, input logic [31:0] act_sel_big,
                             input logic [31:0] exp);
        fetch_addr = a;
        #1;
        if (act_sel_big != 0) chk(nm, b_data, exp);
        else                  chk(nm, s_data, exp);
    endtask

    initial begin
        rst = 1'b1; fetch_addr = 32'd0; fetch_ce = 1'b0;
        ld_start = 1'b0; ld_byte = 8'd0; ld_valid = 1'b0; ld_last = 1'b0;
        tick(); tick();
        rst = 1'b0;
        fetch_ce = 1'b1;
        repeat (5) tick();
        chk("idle core_rst", 32'(b_core_rst), 32'd1);
        chk("idle ready",    32'(b_ready),    32'd0);
        chk("idle fetch",    b_data,          32'h00000013);

        // two-word program
        img = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        load_image(1, 0);
        chk("prog words",    32'(b_words),    32'd2);
        chk("prog done",     32'(b_done),     32'd1);
        chk("prog rst gap",  32'(b_core_rst), 32'd1);
        tick();
        chk("prog rst rel",  32'(b_core_rst), 32'd0);
        fetch_chk("prog addr0", 32'd0, 1, 32'h00100513);
        fetch_chk("prog addr4", 32'd4, 1, 32'h00200593);
        fetch_chk("prog addr5", 32'd5, 1, 32'h00200593);
`ifdef IMEM_BOUNDS_CHECK_EN
        fetch_chk("bounds nop", 32'h10, 1, NOP);
        tick();
        chk("bounds fault", 32'(b_fault), 32'd1);
        fetch_addr = 32'd0;
        tick();
        chk("bounds fault end", 32'(b_fault), 32'd0);
`endif
        fetch_addr = 32'd0;
        tick();

        // six-byte image, partial last word
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        load_image(1, 0);
        tick();
        chk("six words", 32'(b_words), 32'd2);
        fetch_chk("six addr4", 32'd4, 1, 32'h00002211);
        fetch_chk("six addr0", 32'd0, 1, 32'hDDCCBBAA);
        tick();

        // gapped handshake
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        load_image(1, 1);
        tick();
        chk("gap words", 32'(b_words), 32'd2);
        fetch_chk("gap addr0", 32'd0, 1, 32'h04030201);
        fetch_chk("gap addr4", 32'd4, 1, 32'h08070605);
        tick();

        // 20-byte image: overflows the 4-word instance
        img.delete();
        for (int i = 0; i < 20; i++) img.push_back(8'(i));
        load_image(1, 0);
        tick();
        chk("ovf small flag",  32'(s_ovf),   32'd1);
        chk("ovf small words", 32'(s_words), 32'd4);
        chk("ovf big flag",    32'(b_ovf),   32'd0);
        chk("ovf big words",   32'(b_words), 32'd5);
        fetch_chk("ovf small addr12", 32'd12, 0, 32'h0F0E0D0C);
        fetch_chk("ovf small addr0",  32'd0,  0, 32'h03020100);
        fetch_chk("ovf big addr16",   32'd16, 1, 32'h13121110);
        fetch_addr = 32'd0;
        tick();

        // reload from RUN
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        chk("reload core_rst", 32'(b_core_rst), 32'd1);
        chk("reload fetch",    b_data,          NOP);
        chk("reload ready",    32'(b_ready),    32'd1);
        chk("reload ovf clr",  32'(s_ovf),      32'd0);
        img = '{8'h78, 8'h56, 8'h34, 8'h12};
        load_image(0, 0);
        tick();
        fetch_chk("reload addr0", 32'd0, 1, 32'h12345678);
        fetch_chk("reload small addr0", 32'd0, 0, 32'h12345678);
        tick();

        // reset in the middle of a load
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_byte  = 8'hC0 + 8'(i);
            tick();
        end
        ld_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst ready",    32'(b_ready),    32'd0);
        chk("midrst words",    32'(b_words),    32'd0);
        chk("midrst core_rst", 32'(b_core_rst), 32'd1);
        chk("midrst fetch",    b_data,          NOP);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
